// File: rtl/joy_db9_scanner.sv
// Scanner for a 74HC165-style DB9/JAMMA joystick chain, with a 165 emulation
// towards the MCU port and a legacy passthrough mode.
module joy_db9_scanner #(
    parameter int CLK_DIV      = 25,
    parameter int N_JOY        = 2,
    parameter int BITS_PER_JOY = 12,
    parameter int SCAN_GAP     = 1000
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    input  logic                          MODE,
    output logic                          JOY_CLK,
    output logic                          JOY_LOAD_N,
    input  logic                          JOY_DATA,
    input  logic                          XJOY_CLK,
    input  logic                          XJOY_LOAD_N,
    output logic                          XJOY_DATA,
    output logic [N_JOY*BITS_PER_JOY-1:0] JOY_STATE,
    output logic                          FRAME_STB
);

    localparam int N    = N_JOY * BITS_PER_JOY;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int CMAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(SCAN_GAP - 1);
    localparam logic [IW-1:0] LAST    = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LO,
        HI,
        DONE
    } state_t;

    logic mode_s1, mode_r;
    logic data_s1, data_s2;
    logic xclk_s1, xclk_s2, xclk_d;
    logic xload_s1, xload_s2;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          clk_q, load_q, stb_q;
    logic          div_done;

    logic [N-1:0] shift, shift_nx;
    logic [N-1:0] raw_frame, shadow, joy_state;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            mode_s1  <= 1'b0;
            mode_r   <= 1'b0;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            xclk_s1  <= 1'b1;
            xclk_s2  <= 1'b1;
            xload_s1 <= 1'b1;
            xload_s2 <= 1'b1;
        end else begin
            mode_s1  <= MODE;
            mode_r   <= mode_s1;
            data_s1  <= JOY_DATA;
            data_s2  <= data_s1;
            xclk_s1  <= XJOY_CLK;
            xclk_s2  <= xclk_s1;
            xload_s1 <= XJOY_LOAD_N;
            xload_s2 <= xload_s1;
        end
    end

    assign div_done = (cnt == DIV_END);

    // Wire bit i lands at N-1-i, so the first bit shifted out is the MSB.
    always_comb begin
        shift_nx             = shift;
        shift_nx[LAST - idx] = data_s2;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            clk_q     <= 1'b0;
            load_q    <= 1'b1;
            stb_q     <= 1'b0;
            shift     <= '1;
            raw_frame <= '1;
            joy_state <= '0;
        end else if (!mode_r) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            clk_q  <= 1'b0;
            load_q <= 1'b1;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cnt == GAP_END) begin
                        cnt    <= '0;
                        load_q <= 1'b0;
                        state  <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (div_done) begin
                        cnt    <= '0;
                        idx    <= '0;
                        load_q <= 1'b1;
                        state  <= LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LO: begin
                    if (div_done) begin
                        cnt   <= '0;
                        shift <= shift_nx;
                        if (idx == LAST) begin
                            joy_state <= ~shift_nx;
                            raw_frame <= shift_nx;
                            stb_q     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            clk_q <= 1'b1;
                            state <= HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (div_done) begin
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        clk_q <= 1'b0;
                        state <= LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load stays transparent so a frame finishing mid-load is picked up.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            shadow <= '1;
            xclk_d <= 1'b1;
        end else begin
            xclk_d <= xclk_s2;
            if (!xload_s2) begin
                shadow <= raw_frame;
            end else if (xclk_s2 && !xclk_d) begin
                shadow <= {shadow[N-2:0], 1'b1};
            end
        end
    end

    assign JOY_CLK    = mode_r ? clk_q        : XJOY_CLK;
    assign JOY_LOAD_N = mode_r ? load_q       : XJOY_LOAD_N;
    assign XJOY_DATA  = mode_r ? shadow[N-1]  : JOY_DATA;
    assign JOY_STATE  = joy_state;
    assign FRAME_STB  = stb_q;

endmodule
